// File: rtl/mips_cpu_muldiv_seq.sv
// mips_cpu_muldiv_seq: iterative multiply/divide unit that owns the HI/LO pair.
// A shift-add multiplier or restoring divider runs for 32 steps on operand
// magnitudes. One FIX cycle then applies the result signs and writes HI/LO.
// MTHI/MTLO write HI/LO directly and never stall.
module mips_cpu_muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_content,
    input  logic [31:0] rt_content,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] FnMthi  = 6'h11;
    localparam logic [5:0] FnMtlo  = 6'h13;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1a;
    localparam logic [5:0] FnDivu  = 6'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } stateT;

    stateT       state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvdQuo_q, dvdQuo_d;
    logic [31:0] divisor_q, divisor_d;
    logic        isDiv_q, isDiv_d;
    logic        negProd_q, negProd_d;
    logic        negQuot_q, negQuot_d;
    logic        negRem_q, negRem_d;
    logic        divZero_q, divZero_d;
    logic [31:0] rawRs_q, rawRs_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    // Operand decode: only MULT and DIV treat their operands as signed.
    // Negating 0x80000000 yields 0x80000000, which is the correct 32-bit
    // unsigned magnitude, so the most negative value needs no special case.
    logic        isSignedOp;
    logic        rsNeg;
    logic        rtNeg;
    logic [31:0] rsMag;
    logic [31:0] rtMag;

    assign isSignedOp = (funct == FnMult) || (funct == FnDiv);
    assign rsNeg      = isSignedOp & rs_content[31];
    assign rtNeg      = isSignedOp & rt_content[31];
    assign rsMag      = rsNeg ? (32'd0 - rs_content) : rs_content;
    assign rtMag      = rtNeg ? (32'd0 - rt_content) : rt_content;

    // Restoring divide step. The shifted partial remainder needs 33 bits.
    // Whenever the subtraction is kept, its result is below the divisor, so
    // a 32-bit difference is exact.
    logic [32:0] remShift;
    logic        remFits;
    logic [31:0] remSub;

    assign remShift = {rem_q, dvdQuo_q[31]};
    assign remFits  = remShift >= {1'b0, divisor_q};
    assign remSub   = remShift[31:0] - divisor_q;

    // Sign-corrected results consumed in the FIX cycle.
    logic [63:0] prodFixed;
    logic [31:0] quotFixed;
    logic [31:0] remFixed;

    assign prodFixed = negProd_q ? (64'd0 - acc_q) : acc_q;
    assign quotFixed = negQuot_q ? (32'd0 - dvdQuo_q) : dvdQuo_q;
    assign remFixed  = negRem_q ? (32'd0 - rem_q) : rem_q;

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= 5'd0;
            acc_q     <= 64'd0;
            mcand_q   <= 64'd0;
            mplier_q  <= 32'd0;
            rem_q     <= 32'd0;
            dvdQuo_q  <= 32'd0;
            divisor_q <= 32'd0;
            isDiv_q   <= 1'b0;
            negProd_q <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            divZero_q <= 1'b0;
            rawRs_q   <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            dvdQuo_q  <= dvdQuo_d;
            divisor_q <= divisor_d;
            isDiv_q   <= isDiv_d;
            negProd_q <= negProd_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            divZero_q <= divZero_d;
            rawRs_q   <= rawRs_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: issue decode in IDLE, one iteration per cycle in
    // MUL/DIV, and the result write-back in FIX.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        dvdQuo_d  = dvdQuo_q;
        divisor_d = divisor_q;
        isDiv_d   = isDiv_q;
        negProd_d = negProd_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        divZero_d = divZero_q;
        rawRs_d   = rawRs_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    case (funct)
                        FnMult, FnMultu: begin
                            mcand_d   = {32'd0, rsMag};
                            mplier_d  = rtMag;
                            acc_d     = 64'd0;
                            negProd_d = rsNeg ^ rtNeg;
                            isDiv_d   = 1'b0;
                            count_d   = 5'd0;
                            state_d   = MUL;
                        end
                        FnDiv, FnDivu: begin
                            dvdQuo_d  = rsMag;
                            divisor_d = rtMag;
                            rem_d     = 32'd0;
                            negQuot_d = rsNeg ^ rtNeg;
                            negRem_d  = rsNeg;
                            divZero_d = (rt_content == 32'd0);
                            rawRs_d   = rs_content;
                            isDiv_d   = 1'b1;
                            count_d   = 5'd0;
                            state_d   = DIV;
                        end
                        FnMthi: hi_d = rs_content;
                        FnMtlo: lo_d = rs_content;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            DIV: begin
                if (remFits) begin
                    rem_d    = remSub;
                    dvdQuo_d = {dvdQuo_q[30:0], 1'b1};
                end else begin
                    rem_d    = remShift[31:0];
                    dvdQuo_d = {dvdQuo_q[30:0], 1'b0};
                end
                count_d = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (isDiv_q) begin
                    if (divZero_q) begin
                        lo_d = 32'hFFFF_FFFF;
                        hi_d = rawRs_q;
                    end else begin
                        lo_d = quotFixed;
                        hi_d = remFixed;
                    end
                end else begin
                    hi_d = prodFixed[63:32];
                    lo_d = prodFixed[31:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Testbench for mips_cpu_muldiv_seq: a vector table plus hand-written corner
// sequences. Expected HI/LO values are queued at issue and checked on done.
module tb_mips_cpu_muldiv_seq;

    localparam logic [5:0] FnMthi  = 6'h11;
    localparam logic [5:0] FnMtlo  = 6'h13;
    localparam logic [5:0] FnMult  = 6'h18;
    localparam logic [5:0] FnMultu = 6'h19;
    localparam logic [5:0] FnDiv   = 6'h1a;
    localparam logic [5:0] FnDivu  = 6'h1b;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] rsContent;
    logic [31:0] rtContent;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int testsRun    = 0;
    int testsFailed = 0;
    int doneCount   = 0;

    typedef struct {
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] expHi;
        logic [31:0] expLo;
        string       name;
    } vecT;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } expT;

    vecT vecs[$];
    expT sbQ[$];
    expT sbHead;

    mips_cpu_muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct      (funct),
        .rs_content (rsContent),
        .rt_content (rtContent),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] rs,
                                 input logic [31:0] rt);
        start     = 1'b1;
        funct     = fn;
        rsContent = rs;
        rtContent = rt;
    endtask

    task automatic idleInputs();
        start     = 1'b0;
        funct     = 6'h00;
        rsContent = 32'd0;
        rtContent = 32'd0;
    endtask

    // Issue a mul/div at the current negedge and queue its expected result;
    // returns at the negedge of the first busy cycle with start dropped.
    task automatic issueOp(input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [31:0] expHi,
                           input logic [31:0] expLo, input string name);
        expT e;
        e.hi   = expHi;
        e.lo   = expLo;
        e.name = name;
        applyStimulus(fn, rs, rt);
        sbQ.push_back(e);
        @(negedge clk);
        idleInputs();
    endtask

    // Count busy cycles from the current negedge until done shows up.
    task automatic waitDone(input string name, output int busyCycles);
        bit gotDone;
        gotDone    = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                gotDone = 1'b1;
                break;
            end
            if (busy) busyCycles++;
            @(negedge clk);
        end
        if (!gotDone) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s timeout: got no done within 100 cycles, expected done", name);
        end
    endtask

    // Scoreboard: every done pulse pops and compares one queued result.
    always @(negedge clk) begin
        if (done) begin
            doneCount++;
            checkOutput("busy during done", {63'd0, busy}, 64'd0);
            if (sbQ.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpected done: got done=1 hi=%h lo=%h, expected no pending result", hi, lo);
            end else begin
                sbHead = sbQ.pop_front();
                checkOutput(sbHead.name, {hi, lo}, {sbHead.hi, sbHead.lo});
            end
        end
    end

    initial begin
        int busyCycles;
        int doneBefore;

        vecs.push_back('{FnMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu max"});
        vecs.push_back('{FnMult,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult -3*7"});
        vecs.push_back('{FnDiv,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2"});
        vecs.push_back('{FnDivu,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, "divu by zero"});
        vecs.push_back('{FnDiv,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div min/-1"});
        vecs.push_back('{FnDiv,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2"});
        vecs.push_back('{FnDiv,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, "div neg by zero"});
        vecs.push_back('{FnMult,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult min*min"});
        vecs.push_back('{FnMultu, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu 2^16*2^16"});
        vecs.push_back('{FnMult,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, "mult 7*-1"});
        vecs.push_back('{FnDivu,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, "divu max/16"});
        vecs.push_back('{FnDivu,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, "divu 100/7"});

        idleInputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset busy", {63'd0, busy}, 64'd0);
        checkOutput("reset done", {63'd0, done}, 64'd0);
        checkOutput("reset hi/lo", {hi, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] mthi/mtlo without stall");
        applyStimulus(FnMthi, 32'hAAAA0000, 32'd0);
        @(negedge clk);
        checkOutput("mthi busy", {63'd0, busy}, 64'd0);
        checkOutput("mthi hi", {32'd0, hi}, {32'd0, 32'hAAAA0000});
        applyStimulus(FnMtlo, 32'h0000BBBB, 32'd0);
        @(negedge clk);
        idleInputs();
        checkOutput("mtlo busy", {63'd0, busy}, 64'd0);
        checkOutput("mtlo hi/lo", {hi, lo}, {32'hAAAA0000, 32'h0000BBBB});
        checkOutput("mthi/mtlo no done", 64'(doneCount), 64'd0);

        $display("[TB] start ignored while busy");
        issueOp(FnMultu, 32'd2, 32'd3, 32'd0, 32'd6, "multu 2*3 ignore start");
        repeat (4) @(negedge clk);
        applyStimulus(FnDivu, 32'd9, 32'd0);
        @(negedge clk);
        idleInputs();
        waitDone("multu 2*3", busyCycles);
        checkOutput("ignored start busy cycles", 64'(busyCycles), 64'd28);
        @(negedge clk);
        checkOutput("ignored start done pulse", {63'd0, done}, 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("single done", 64'(doneCount), 64'd1);

        $display("[TB] vector table");
        for (int v = 0; v < vecs.size(); v++) begin
            issueOp(vecs[v].fn, vecs[v].rs, vecs[v].rt, vecs[v].expHi, vecs[v].expLo, vecs[v].name);
            waitDone(vecs[v].name, busyCycles);
            checkOutput({vecs[v].name, " busy cycles"}, 64'(busyCycles), 64'd33);
            @(negedge clk);
            checkOutput({vecs[v].name, " done width"}, {63'd0, done}, 64'd0);
        end

        $display("[TB] reset mid-operation");
        doneBefore = doneCount;
        applyStimulus(FnMult, 32'd5, 32'd5);
        @(negedge clk);
        idleInputs();
        repeat (9) @(negedge clk);
        checkOutput("busy before reset", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset abort busy", {63'd0, busy}, 64'd0);
        checkOutput("reset abort hi/lo", {hi, lo}, 64'd0);
        repeat (40) @(negedge clk);
        checkOutput("reset abort no done", 64'(doneCount), 64'(doneBefore));
        issueOp(FnMultu, 32'd5, 32'd5, 32'd0, 32'd25, "multu 5*5 after reset");
        waitDone("multu 5*5", busyCycles);
        checkOutput("multu 5*5 busy cycles", 64'(busyCycles), 64'd33);

        $display("[TB] back-to-back issue in done cycle");
        @(negedge clk);
        issueOp(FnMultu, 32'd3, 32'd4, 32'd0, 32'd12, "multu 3*4");
        waitDone("multu 3*4", busyCycles);
        issueOp(FnDivu, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7 back-to-back");
        waitDone("divu 100/7", busyCycles);
        checkOutput("back-to-back busy cycles", 64'(busyCycles), 64'd33);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", 64'(sbQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mips_cpu_muldiv_seq.md
# mips_cpu_muldiv_seq

Multi-cycle multiply/divide sequencer owning the HI/LO register pair of the MIPS CPU. It sits beside the combinational ALU in the execute stage and handles MULT, MULTU, DIV, DIVU, MTHI and MTLO. It runs an iterative shift-add multiplier or restoring divider for 32 iterations, then a sign-fix cycle. It holds `busy` so the control unit stalls MFHI/MFLO and further mul/div issue until HI/LO are valid.

## Interface
Parameters: none (datapath width fixed at 32).

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: issue request, sampled on rising edge.
- `funct` in 6: function field; 0x18 mult, 0x19 multu, 0x1a div, 0x1b divu, 0x11 mthi, 0x13 mtlo.
- `rs_content` in 32: multiplicand, dividend, or MTHI/MTLO source.
- `rt_content` in 32: multiplier or divisor.
- `busy` out 1: operation in flight; the control unit stalls on it.
- `done` out 1: one-cycle pulse, HI/LO newly valid from a mul/div.
- `hi` out 32: HI register (MFHI source).
- `lo` out 32: LO register (MFLO source).

## Operation
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start` + mult/multu:
  - Latch operand magnitudes (absolute value for mult, raw for multu) and the product sign.
  - Clear the 64-bit accumulator and the 5-bit iteration counter; go to MUL.
- IDLE + `start` + div/divu:
  - Latch dividend/divisor magnitudes, quotient sign (sign rs XOR sign rt) and remainder sign (sign rs).
  - Clear the counter; go to DIV.
- IDLE + `start` + mthi/mtlo: write `rs_content` to hi/lo at that edge. State stays IDLE; `busy` and `done` are not asserted.
- IDLE + `start` + any other funct: ignored, no state change.
- MUL: one shift-add step per cycle, using the LSB of the multiplier. Counter increments; when it reaches 31, go to FIX.
- DIV: one restoring step per cycle:
  - Shift the remainder left and bring in the next dividend bit.
  - Subtract the divisor; if the result is non-negative, keep it and set the quotient bit to 1.
  - Counter reaches 31 → FIX.
- FIX:
  - Apply two's-complement negation where the latched signs require it: product; quotient; remainder.
  - Write hi/lo, pulse `done`, return to IDLE.
  - Mult: hi = product[63:32], lo = product[31:0].
  - Div: lo = quotient, hi = remainder.
  - Signed division truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (div and divu): lo = 0xFFFFFFFF, hi = `rs_content` as latched at issue. No sign fix is applied and no exception is raised.
- div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000. This falls out of magnitude arithmetic on the 32-bit unsigned 0x80000000.
- `start` while `busy` = 1 is ignored; operands are not re-latched.
- hi/lo change only at the FIX edge or on an mthi/mtlo issue.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0x00000000, `lo` 0x00000000, counter 0.
- `reset` mid-operation: the next edge returns to IDLE and clears hi/lo; the in-flight result is discarded.
- Mul/div accepted at edge E0:
  - `busy` = 1 in the cycles after edges E0..E32 (33 cycles).
  - MUL/DIV occupy E1..E32; FIX is entered after E32.
  - hi/lo are written at edge E33.
  - In the cycle after E33: `busy` = 0, `done` = 1, new hi/lo visible.
- Total latency: 33 cycles from the accept edge to valid HI/LO. A new `start` may be accepted in the same cycle that `done` = 1.
- mthi/mtlo: zero stall; hi/lo valid in the cycle after the accept edge.
- `done` lasts exactly one cycle and never coincides with `busy` = 1.

## Test plan
- Reset, then multu rs=0xFFFFFFFF rt=0xFFFFFFFF → `busy` high 33 cycles, then `done` = 1; hi = 0xFFFFFFFE, lo = 0x00000001.
- mult rs=0xFFFFFFFD (−3) rt=0x00000007 → hi = 0xFFFFFFFF, lo = 0xFFFFFFEB. div rs=0xFFFFFFF9 (−7) rt=0x00000002 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- divu rs=0x12345678 rt=0 → lo = 0xFFFFFFFF, hi = 0x12345678. div rs=0x80000000 rt=0xFFFFFFFF → lo = 0x80000000, hi = 0.
- Check that mthi/mtlo do not stall and that `start` is ignored while `busy`:
  - mthi 0xAAAA0000, then mtlo 0x0000BBBB on consecutive cycles → hi/lo updated with `busy` never asserted.
  - Then multu 2×3, and at cycle 5 of busy pulse `start` with divu 9/0 → final hi = 0, lo = 6; single `done`.
- Start mult 5×5; assert `reset` at busy cycle 10 → next cycle `busy` = 0, `done` never pulses, hi = lo = 0. A fresh multu 5×5 then yields lo = 25.
- Back-to-back: issue divu 100/7 in the `done` cycle of a prior multu → second result lo = 14, hi = 2, 33 cycles after its accept edge.
